wb_byte_loader: RTL and testbench

Wishbone initiator that writes a byte stream into a 32-bit, byte-enabled Wishbone memory.
- Packs incoming bytes little-endian into 32-bit words, starting at an arbitrary byte address, and issues one write per touched word with matching `o_wb_sel`.
- Unaligned heads and tails become partial-word writes.
- Sits in front of the on-chip RAM to preload or patch its contents at run time, e.g. from a debug UART or boot source.

---
 rtl/wb_byte_loader.sv | 94 +++++++++
 tb/tb_wb_byte_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_loader.sv
// Wishbone initiator that packs a byte stream little-endian into 32-bit words
// and writes each touched word with the matching byte-lane enables.
module wb_byte_loader #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_start,
  input  logic [aw-1:0] i_base_adr,
  input  logic [aw:0]   i_len,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_valid,
  output logic          o_byte_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic [aw-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  input  logic          i_wb_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [aw-1:0] ptr;
  logic [aw-1:0] adr;
  logic [aw:0]   rem;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic [1:0]    lane;

  assign lane = ptr[1:0];

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      adr   <= '0;
      rem   <= '0;
      dat   <= '0;
      sel   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            ptr   <= i_base_adr;
            rem   <= i_len;
            state <= (i_len != '0) ? S_FILL : S_DONE;
          end
        end
        S_FILL: begin
          if (i_byte_valid) begin
            dat[{lane, 3'b000} +: 8] <= i_byte;
            sel[lane]                <= 1'b1;
            // Word address comes from the pre-increment pointer, so a word
            // split by the address wrap flushes at the top word first.
            adr <= {ptr[aw-1:2], 2'b00};
            ptr <= ptr + aw'(1);
            rem <= rem - (aw+1)'(1);
            if (lane == 2'd3 || rem == (aw+1)'(1))
              state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (i_wb_ack) begin
            sel   <= '0;
            dat   <= '0;
            state <= (rem != '0) ? S_FILL : S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_byte_ready = (state == S_FILL);
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign o_wb_cyc     = (state == S_WRITE);
  assign o_wb_stb     = o_wb_cyc;
  assign o_wb_we      = o_wb_cyc;
  assign o_wb_adr     = adr;
  assign o_wb_dat     = dat;
  assign o_wb_sel     = sel;

endmodule

// File: tb/tb_wb_byte_loader.sv
// Randomized bench for wb_byte_loader: byte-addressed memory model, Wishbone
// responder with configurable ack delay, and per-scenario checks.
module tb_wb_byte_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          i_wb_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_adr = '0;
  logic [AW:0]   i_len = '0;
  logic [7:0]    i_byte = '0;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready, o_busy, o_done;
  logic [AW-1:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we, o_wb_cyc, o_wb_stb;
  logic          i_wb_ack = 1'b0;

  always #5 clk = ~clk;

  wb_byte_loader #(.depth(DEPTH), .aw(AW)) dut (
    .i_wb_clk(clk), .i_wb_rst(i_wb_rst), .i_start(i_start),
    .i_base_adr(i_base_adr), .i_len(i_len), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_busy(o_busy), .o_done(o_done), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]    src[DEPTH];
  logic [7:0]    mem[DEPTH];
  logic [7:0]    exp_mem[DEPTH];
  logic [AW-1:0] wr_adr[$], ex_adr[$];
  logic [31:0]   wr_dat[$], ex_dat[$];
  logic [3:0]    wr_sel[$], ex_sel[$];

  int t, done_t, last_ack_t, done_cnt, hold_err, rdy_err, prot_err, busy_err, cyc_seen;
  bit timeout, aborted, done_seen;
  logic [AW+44:0] rst_snap;

  // Reference: byte i lands at (base+i) mod depth; consecutive bytes in the
  // same word share one write, a new word starts a new write.
  task automatic build_expect(input int base, input int len);
    int cur, a;
    ex_adr.delete(); ex_dat.delete(); ex_sel.delete();
    exp_mem = mem;
    cur = -1;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      if (a / 4 != cur) begin
        cur = a / 4;
        ex_adr.push_back(AW'(cur * 4));
        ex_dat.push_back(32'h0);
        ex_sel.push_back(4'h0);
      end
      ex_dat[ex_dat.size()-1] = ex_dat[ex_dat.size()-1] | (32'(src[i]) << (8 * (a % 4)));
      ex_sel[ex_sel.size()-1] = ex_sel[ex_sel.size()-1] | (4'b0001 << (a % 4));
      exp_mem[a] = src[i];
    end
  endtask

  task automatic run_xfer(input int base, input int len, input int stall, input int dly,
                          input bit spur, input bit junk, input bit abort);
    int idx, wcnt, limit;
    bit real_ack, v;
    logic [AW-1:0] h_adr;
    logic [31:0]   h_dat;
    logic [3:0]    h_sel;
    wr_adr.delete(); wr_dat.delete(); wr_sel.delete();
    done_cnt = 0; hold_err = 0; rdy_err = 0; prot_err = 0; busy_err = 0; cyc_seen = 0;
    done_t = -1; last_ack_t = -1; timeout = 0; aborted = 0; done_seen = 0;
    idx = 0; wcnt = 0; real_ack = 0; t = 0;
    h_adr = '0; h_dat = '0; h_sel = '0;
    limit = 100 + len * (20 + dly);
    @(negedge clk);
    i_start = 1'b1; i_base_adr = AW'(base); i_len = (AW+1)'(len);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      t++;
      if (aborted) begin
        rst_snap = {o_byte_ready, o_busy, o_done, o_wb_adr, o_wb_dat, o_wb_sel,
                    o_wb_we, o_wb_cyc, o_wb_stb};
        i_wb_rst = 1'b0; i_wb_ack = 1'b0; i_byte_valid = 1'b0; i_start = 1'b0;
        break;
      end
      if (o_wb_cyc !== o_wb_stb || o_wb_cyc !== o_wb_we) prot_err++;
      if (o_busy !== !done_seen) busy_err++;
      if (o_done) begin
        done_cnt++;
        if (!done_seen) done_t = t;
        done_seen = 1;
      end
      if (o_wb_cyc) cyc_seen++;
      // Responder: ack after dly wait cycles, optional stray acks while idle.
      if (i_wb_ack) begin
        if (real_ack && o_wb_cyc) prot_err++;
        i_wb_ack = 1'b0; real_ack = 0; wcnt = 0;
      end else if (o_wb_cyc) begin
        if (o_byte_ready) rdy_err++;
        if (o_wb_adr[1:0] != 2'b00 || o_wb_sel == 4'h0) prot_err++;
        for (int j = 0; j < 4; j++)
          if (!o_wb_sel[j] && o_wb_dat[8*j +: 8] != 8'h00) prot_err++;
        if (wcnt == 0) begin
          h_adr = o_wb_adr; h_dat = o_wb_dat; h_sel = o_wb_sel;
        end else if (o_wb_adr !== h_adr || o_wb_dat !== h_dat || o_wb_sel !== h_sel) begin
          hold_err++;
        end
        if (abort && wcnt == 1) begin
          i_wb_rst = 1'b1; aborted = 1;
        end else if (wcnt == dly) begin
          i_wb_ack = 1'b1; real_ack = 1; last_ack_t = t;
          wr_adr.push_back(o_wb_adr); wr_dat.push_back(o_wb_dat); wr_sel.push_back(o_wb_sel);
          for (int j = 0; j < 4; j++)
            if (o_wb_sel[j]) mem[(int'(o_wb_adr) + j) % DEPTH] = o_wb_dat[8*j +: 8];
        end
        wcnt++;
      end else if (spur && $urandom_range(0, 3) == 0) begin
        i_wb_ack = 1'b1; real_ack = 0;
      end
      // Stream driver and ignored start requests while busy.
      if (junk && !done_seen) begin
        i_start = 1'($urandom_range(0, 1));
        i_base_adr = AW'($urandom); i_len = (AW+1)'($urandom_range(0, DEPTH));
      end else begin
        i_start = 1'b0;
      end
      if (idx < len) begin
        v = ($urandom_range(0, 99) >= stall);
        i_byte_valid = v;
        i_byte = v ? src[idx] : 8'($urandom);
        if (v && o_byte_ready) idx++;
      end else begin
        i_byte_valid = 1'b0; i_byte = 8'($urandom);
      end
      if (done_seen && t > done_t) break;
    end
    if (!done_seen && !aborted) timeout = 1;
    i_start = 1'b0; i_byte_valid = 1'b0; i_wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW+44:0] o;
    i_wb_rst = 1'b1;
    repeat (3) @(negedge clk);
    o = {o_byte_ready, o_busy, o_done, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", o); end
    i_wb_rst = 1'b0;
    repeat (2) @(negedge clk);
    o = {o_byte_ready, o_busy, o_done, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL idle_outputs got=%h exp=0", o); end
  endtask

  task automatic test_aligned();
    logic [AW-1:0] ea[2];
    logic [31:0]   ed[2];
    ea[0] = 8'h10; ea[1] = 8'h14; ed[0] = 32'h04030201; ed[1] = 32'h08070605;
    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    run_xfer(16, 8, 0, 0, 0, 0, 0);
    checks++;
    if (timeout || wr_adr.size() != 2) begin
      errors++; $display("FAIL aligned_count got=%0d exp=2 timeout=%0d", wr_adr.size(), timeout);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_adr[i] !== ea[i] || wr_dat[i] !== ed[i] || wr_sel[i] !== 4'hf) begin
          errors++;
          $display("FAIL aligned_write%0d got=%h/%h/%b exp=%h/%h/1111", i, wr_adr[i], wr_dat[i], wr_sel[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (done_t != 11 || last_ack_t != 10 || done_cnt != 1) begin
      errors++; $display("FAIL aligned_timing done_t=%0d ack_t=%0d cnt=%0d exp=11/10/1", done_t, last_ack_t, done_cnt);
    end
    checks++;
    if (prot_err + busy_err + hold_err + rdy_err != 0) begin
      errors++; $display("FAIL aligned_protocol prot=%0d busy=%0d hold=%0d rdy=%0d exp=0", prot_err, busy_err, hold_err, rdy_err);
    end
  endtask

  task automatic test_unaligned();
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
    run_xfer(8'h13, 3, 0, 0, 0, 0, 0);
    checks++;
    if (timeout || wr_adr.size() != 2) begin
      errors++; $display("FAIL unaligned_count got=%0d exp=2 timeout=%0d", wr_adr.size(), timeout);
    end else begin
      checks++;
      if (wr_adr[0] !== 8'h10 || wr_dat[0] !== 32'hAA000000 || wr_sel[0] !== 4'b1000) begin
        errors++; $display("FAIL unaligned_head got=%h/%h/%b exp=10/aa000000/1000", wr_adr[0], wr_dat[0], wr_sel[0]);
      end
      checks++;
      if (wr_adr[1] !== 8'h14 || wr_dat[1] !== 32'h0000CCBB || wr_sel[1] !== 4'b0011) begin
        errors++; $display("FAIL unaligned_tail got=%h/%h/%b exp=14/0000ccbb/0011", wr_adr[1], wr_dat[1], wr_sel[1]);
      end
    end
    checks++;
    if (done_t != 6 || done_cnt != 1) begin
      errors++; $display("FAIL unaligned_done done_t=%0d cnt=%0d exp=6/1", done_t, done_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_xfer(int'($urandom_range(0, DEPTH-1)), 0, 0, 0, 1, 0, 0);
    checks++;
    if (cyc_seen != 0 || wr_adr.size() != 0) begin
      errors++; $display("FAIL zero_no_bus got cyc_cycles=%0d writes=%0d exp=0/0", cyc_seen, wr_adr.size());
    end
    checks++;
    if (timeout || done_t != 1 || done_cnt != 1 || busy_err != 0) begin
      errors++; $display("FAIL zero_done done_t=%0d cnt=%0d busy_err=%0d exp=1/1/0", done_t, done_cnt, busy_err);
    end
  endtask

  task automatic test_ack_wait();
    int base;
    base = int'($urandom_range(0, DEPTH-1));
    for (int i = 0; i < 13; i++) src[i] = 8'($urandom);
    build_expect(base, 13);
    run_xfer(base, 13, 50, 3, 0, 0, 0);
    checks++;
    if (hold_err != 0 || rdy_err != 0 || prot_err != 0) begin
      errors++; $display("FAIL wait_hold hold=%0d rdy=%0d prot=%0d exp=0", hold_err, rdy_err, prot_err);
    end
    checks++;
    if (timeout || wr_adr.size() != ex_adr.size()) begin
      errors++; $display("FAIL wait_count got=%0d exp=%0d timeout=%0d", wr_adr.size(), ex_adr.size(), timeout);
    end else begin
      for (int i = 0; i < ex_adr.size(); i++) begin
        checks++;
        if (wr_adr[i] !== ex_adr[i] || wr_dat[i] !== ex_dat[i] || wr_sel[i] !== ex_sel[i]) begin
          errors++;
          $display("FAIL wait_write%0d got=%h/%h/%b exp=%h/%h/%b", i, wr_adr[i], wr_dat[i], wr_sel[i], ex_adr[i], ex_dat[i], ex_sel[i]);
        end
      end
    end
    checks++;
    if (done_t != last_ack_t + 1 || done_cnt != 1) begin
      errors++; $display("FAIL wait_done done_t=%0d exp=%0d cnt=%0d", done_t, last_ack_t + 1, done_cnt);
    end
  endtask

  task automatic test_wrap();
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    run_xfer(8'hFE, 4, 0, 1, 0, 0, 0);
    checks++;
    if (timeout || wr_adr.size() != 2) begin
      errors++; $display("FAIL wrap_count got=%0d exp=2 timeout=%0d", wr_adr.size(), timeout);
    end else begin
      checks++;
      if (wr_adr[0] !== 8'hFC || wr_dat[0] !== 32'h22110000 || wr_sel[0] !== 4'b1100) begin
        errors++; $display("FAIL wrap_top got=%h/%h/%b exp=fc/22110000/1100", wr_adr[0], wr_dat[0], wr_sel[0]);
      end
      checks++;
      if (wr_adr[1] !== 8'h00 || wr_dat[1] !== 32'h00004433 || wr_sel[1] !== 4'b0011) begin
        errors++; $display("FAIL wrap_bottom got=%h/%h/%b exp=00/00004433/0011", wr_adr[1], wr_dat[1], wr_sel[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) src[i] = 8'($urandom);
    run_xfer(8'h20, 6, 0, 10, 0, 0, 1);
    checks++;
    if (!aborted || rst_snap !== '0 || done_cnt != 0) begin
      errors++; $display("FAIL reset_mid got aborted=%0d outs=%h done=%0d exp=1/0/0", aborted, rst_snap, done_cnt);
    end
    for (int i = 0; i < 5; i++) src[i] = 8'(8'hC0 + i);
    build_expect(8'h31, 5);
    run_xfer(8'h31, 5, 0, 0, 0, 0, 0);
    checks++;
    if (timeout || wr_adr.size() != 2 || wr_adr[0] !== 8'h30 || wr_dat[0] !== 32'hC2C1C000 ||
        wr_sel[0] !== 4'b1110 || wr_adr[1] !== 8'h34 || wr_dat[1] !== 32'h0000C4C3 || wr_sel[1] !== 4'b0011) begin
      errors++; $display("FAIL reset_restart writes=%0d first=%h/%h/%b exp=30/c2c1c000/1110", wr_adr.size(), wr_adr[0], wr_dat[0], wr_sel[0]);
    end
  endtask

  task automatic test_random();
    int base, len, bad;
    for (int it = 0; it < 20; it++) begin
      base = int'($urandom_range(0, DEPTH-1));
      len = (it == 7) ? DEPTH : (it == 12) ? 0 : int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) src[i] = 8'($urandom);
      build_expect(base, len);
      run_xfer(base, len, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b1, 1'b0);
      bad = 0;
      if (wr_adr.size() != ex_adr.size()) bad++;
      else
        for (int i = 0; i < ex_adr.size(); i++)
          if (wr_adr[i] !== ex_adr[i] || wr_dat[i] !== ex_dat[i] || wr_sel[i] !== ex_sel[i]) bad++;
      checks++;
      if (timeout || bad != 0) begin
        errors++; $display("FAIL rand%0d_writes base=%0d len=%0d got=%0d exp=%0d bad=%0d", it, base, len, wr_adr.size(), ex_adr.size(), bad);
      end
      bad = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_mem[a]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand%0d_memory got bad_bytes=%0d exp=0", it, bad);
      end
      checks++;
      if (done_cnt != 1 || prot_err + busy_err + hold_err + rdy_err != 0 ||
          (len > 0 && done_t != last_ack_t + 1) || (len == 0 && done_t != 1)) begin
        errors++; $display("FAIL rand%0d_protocol done=%0d done_t=%0d ack_t=%0d prot=%0d busy=%0d hold=%0d rdy=%0d exp=1,ack+1,0",
                           it, done_cnt, done_t, last_ack_t, prot_err, busy_err, hold_err, rdy_err);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
    test_reset();
    test_aligned();
    test_unaligned();
    test_zero_len();
    test_ack_wait();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
